// File: rtl/cmp_minmax_seq_if.sv
// Sample-in / result-out handshake bundle for cmp_minmax_seq.
// Index fields exist only when CMP_MINMAX_IDX_EN is defined.
interface cmp_minmax_seq_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 3
) ();

  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_ready;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_max;
  logic signed [WIDTH-1:0] out_min;
`ifdef CMP_MINMAX_IDX_EN
  logic [IDXW-1:0]         out_max_idx;
  logic [IDXW-1:0]         out_min_idx;
`endif

  // Source of samples and consumer of results.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_max,
    input  out_min
`ifdef CMP_MINMAX_IDX_EN
    ,
    input  out_max_idx,
    input  out_min_idx
`endif
  );

  // The sequencer itself.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_max,
    output out_min
`ifdef CMP_MINMAX_IDX_EN
    ,
    output out_max_idx,
    output out_min_idx
`endif
  );

endinterface

// File: rtl/cmp_minmax_seq.sv
// Frame min/max finder sharing one signed comparator over time.
// Define CMP_MINMAX_IDX_EN to add min/max position outputs.

module comparator #(
  parameter int width = 4
) (
  input  logic signed [width-1:0] a,
  input  logic signed [width-1:0] b,
  output logic                    equal,
  output logic                    greater,
  output logic                    lower
);

  assign equal   = (a == b);
  assign greater = (a > b);
  assign lower   = (a < b);

endmodule

module cmp_minmax_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  cmp_minmax_seq_if.slave   bus
);

  localparam int CNTW = $clog2(DEPTH + 1);

  localparam logic [CNTW-1:0] LAST = CNTW'(DEPTH - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FIRST   = 3'd1;
  localparam logic [2:0] ACCEPT  = 3'd2;
  localparam logic [2:0] CMP_MAX = 3'd3;
  localparam logic [2:0] CMP_MIN = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0] state;
  logic [2:0] state_nx;

  logic signed [WIDTH-1:0] sample;
  logic signed [WIDTH-1:0] max_q;
  logic signed [WIDTH-1:0] min_q;
  logic signed [WIDTH-1:0] cmp_a;
  logic signed [WIDTH-1:0] cmp_b;
  logic [CNTW-1:0]         count;

  logic eq_w;
  logic gt_w;
  logic lt_w;
  logic take;

`ifdef CMP_MINMAX_IDX_EN
  logic [IDXW-1:0] max_idx;
  logic [IDXW-1:0] min_idx;
`endif

  comparator #(
    .width (WIDTH)
  ) u_cmp (
    .a       (cmp_a),
    .b       (cmp_b),
    .equal   (eq_w),
    .greater (gt_w),
    .lower   (lt_w)
  );

  assign take = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = (state == FIRST) | (state == ACCEPT);
  assign bus.out_valid = (state == DONE);
  assign busy          = (state != IDLE);
  assign bus.out_max   = max_q;
  assign bus.out_min   = min_q;
`ifdef CMP_MINMAX_IDX_EN
  assign bus.out_max_idx = max_idx;
  assign bus.out_min_idx = min_idx;
`endif

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = FIRST;
      FIRST:   if (take) state_nx = (DEPTH == 1) ? DONE : ACCEPT;
      ACCEPT:  if (take) state_nx = CMP_MAX;
      CMP_MAX: state_nx = CMP_MIN;
      CMP_MIN: state_nx = (count == LAST) ? DONE : ACCEPT;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Comparator operands are loaded one cycle ahead of the state that
  // consumes them, and otherwise hold, so nothing loops back combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_a <= '0;
      cmp_b <= '0;
    end else if (state == ACCEPT && take) begin
      cmp_a <= bus.in_data;
      cmp_b <= max_q;
    end else if (state == CMP_MAX) begin
      cmp_b <= min_q;
    end
  end

  // Running extrema, sample register and position counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample <= '0;
      max_q  <= '0;
      min_q  <= '0;
      count  <= '0;
    end else begin
      unique case (state)
        FIRST: if (take) begin
          max_q <= bus.in_data;
          min_q <= bus.in_data;
          count <= CNTW'(1);
        end
        ACCEPT: if (take) sample <= bus.in_data;
        // Ties keep the earlier value and position.
        CMP_MAX: if (gt_w & ~eq_w) max_q <= sample;
        CMP_MIN: begin
          if (lt_w & ~eq_w) min_q <= sample;
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CMP_MINMAX_IDX_EN
  // Positions track the same updates as the extrema.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx <= '0;
      min_idx <= '0;
    end else begin
      unique case (state)
        FIRST: if (take) begin
          max_idx <= '0;
          min_idx <= '0;
        end
        CMP_MAX: if (gt_w & ~eq_w) max_idx <= IDXW'(count);
        CMP_MIN: if (lt_w & ~eq_w) min_idx <= IDXW'(count);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Scoreboard bench for cmp_minmax_seq: DEPTH=8 and DEPTH=1 instances.
// Index checks are compiled in only with CMP_MINMAX_IDX_EN.
module tb_cmp_minmax_seq;

  typedef struct {
    int mx;
    int mn;
    int mxi;
    int mni;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic start1;
  logic busy;
  logic busy1;

  int n_chk;
  int n_pass;

  exp_t sb[$];

  int f1[8] = '{3, -7, 5, 0, 7, -8, 2, 7};
  int f2[8] = '{-3, -3, -3, -3, -3, -3, -3, -3};
  int f4[8] = '{2, 1, 1, 1, 1, 1, 1, 1};
  int f5[8] = '{1, 2, 3, 4, -1, -2, 0, 5};

  cmp_minmax_seq_if #(.WIDTH(4), .IDXW(3)) m ();
  cmp_minmax_seq_if #(.WIDTH(4), .IDXW(1)) m1 ();

  cmp_minmax_seq #(.WIDTH(4), .DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .bus   (m)
  );

  cmp_minmax_seq #(.WIDTH(4), .DEPTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .busy  (busy1),
    .bus   (m1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d exp %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int s[8]);
    exp_t e;
    e.mx = s[0];
    e.mn = s[0];
    e.mxi = 0;
    e.mni = 0;
    for (int i = 1; i < 8; i++) begin
      if (s[i] > e.mx) begin
        e.mx = s[i];
        e.mxi = i;
      end
      if (s[i] < e.mn) begin
        e.mn = s[i];
        e.mni = i;
      end
    end
    return e;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    m.in_valid = 1'b1;
    m.in_data = 4'(v);
    while (!m.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!m.in_ready) chk("in_ready_timeout", 0, 1);
    tick();
    m.in_valid = 1'b0;
  endtask

  task automatic collect(input int hold, input bit poke);
    int n;
    exp_t e;
    n = 0;
    while (!m.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, 2);
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", int'(m.out_valid), 1);
      if (poke && k == 1) pulse_start();
      else tick();
    end
    m.out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("valid", int'(m.out_valid), 1);
      chk("max", int'($signed(m.out_max)), e.mx);
      chk("min", int'($signed(m.out_min)), e.mn);
`ifdef CMP_MINMAX_IDX_EN
      chk("max_idx", int'(m.out_max_idx), e.mxi);
      chk("min_idx", int'(m.out_min_idx), e.mni);
`endif
    end
    tick();
    m.out_ready = 1'b0;
    chk("valid_drop", int'(m.out_valid), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic run_frame(input int s[8], input int gap_at,
                           input int gap_len, input int hold,
                           input bit poke);
    sb.push_back(model(s));
    pulse_start();
    chk("busy_start", int'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      send(s[i]);
      if (i == gap_at) repeat (gap_len) tick();
      if (poke && i == 2) begin
        chk("cmp_in_ready", int'(m.in_ready), 0);
        pulse_start();
      end
    end
    collect(hold, poke);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    m.in_valid = 1'b0;
    m.in_data = '0;
    m.out_ready = 1'b0;
    m1.in_valid = 1'b0;
    m1.in_data = '0;
    m1.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(m.in_ready), 0);
    chk("rst_valid", int'(m.out_valid), 0);
    chk("rst_max", int'($signed(m.out_max)), 0);
    chk("rst_min", int'($signed(m.out_min)), 0);
    chk("rst1_busy", int'(busy1), 0);

    run_frame(f1, -1, 0, 0, 1'b0);
    run_frame(f2, -1, 0, 0, 1'b0);
    run_frame(f1, 1, 5, 4, 1'b0);

    pulse_start();
    for (int i = 0; i < 4; i++) send(f1[i]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(m.out_valid), 0);
    chk("mid_rst_max", int'($signed(m.out_max)), 0);
    chk("mid_rst_min", int'($signed(m.out_min)), 0);
    run_frame(f4, -1, 0, 0, 1'b0);

    run_frame(f5, -1, 0, 3, 1'b1);
    repeat (5) tick();
    chk("no_extra_valid", int'(m.out_valid), 0);
    chk("no_extra_busy", int'(busy), 0);

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    m1.in_valid = 1'b1;
    m1.in_data = 4'(-6);
    chk("d1_in_ready", int'(m1.in_ready), 1);
    tick();
    m1.in_valid = 1'b0;
    chk("d1_valid", int'(m1.out_valid), 1);
    chk("d1_max", int'($signed(m1.out_max)), -6);
    chk("d1_min", int'($signed(m1.out_min)), -6);
`ifdef CMP_MINMAX_IDX_EN
    chk("d1_max_idx", int'(m1.out_max_idx), 0);
    chk("d1_min_idx", int'(m1.out_min_idx), 0);
`endif
    m1.out_ready = 1'b1;
    tick();
    m1.out_ready = 1'b0;
    chk("d1_valid_drop", int'(m1.out_valid), 0);
    chk("d1_busy", int'(busy1), 0);

    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
